id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the five-stage MIPS pipeline; sits directly upstream of the ALU control decoder and the ALU.
- Captures decoded control (ALUop, Func, datapath selects, memory/writeback enables) and operands from ID, and presents them to EX one cycle later.
- Contains load-use hazard detection, bubble insertion, branch flush, downstream hold, and a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width (register data, immediate, PC+4).
- CW, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_ALUop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type (use Func); 11 unused.
- id_Func  in  6  instruction funct field.
- id_RegDst, id_ALUSrc, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_Branch  in  1 each  main-control outputs.
- id_rs_data, id_rt_data, id_imm, id_pc4  in  DW each  operands, sign-extended immediate, PC+4.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- flush  in  1  branch taken in MEM; kill the ID instruction.
- hold  in  1  downstream stall; freeze this register.
- ex_*  out  same widths as the id_* inputs above  registered copies (ex_valid, ex_ALUop, ex_Func, …, ex_rd).
- load_use_stall  out  1  combinational; freezes PC and IF/ID.
- bubble_cnt  out  CW  count of inserted bubbles, saturating.

Behaviour:
- Reset (synchronous, active-high): every ex_* output is 0 and bubble_cnt is 0. A reset asserted mid-operation overrides everything else in that cycle.
- load_use_stall = id_valid & ex_valid & ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush.
  - Output only; it does not depend on hold.
- Per-edge update priority, highest first:
  1. reset.
  2. hold: all ex_* keep their values; no bubble is counted.
     - A simultaneous flush is not lost: flush wins over hold (see next item).
  3. flush: load a bubble.
  4. load_use_stall: load a bubble and increment bubble_cnt.
  5. otherwise: load all id_* into ex_*, including ex_valid = id_valid.
- Correction to the ordering above: flush is priority 2 and hold is priority 3. The required order is reset > flush > hold > load_use bubble > load.
  - Rationale: a taken branch must kill the instruction even during a downstream stall.
- Bubble contents:
  - ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_MemtoReg = 0.
  - ex_ALUop = 00, ex_Func = 0.
  - Data and specifier fields = 0, so the EX stage sees a deterministic NOP.
- Flush-inserted bubbles do not increment bubble_cnt; only load-use bubbles do.
- bubble_cnt saturates at all-ones and never wraps.
- Latency: exactly one cycle from ID to EX when not held.
- Throughput: one instruction per cycle.
- The ALUop value 11 passes through unchanged; there is no checking in this block.
- The specifier check uses ex_rt only, because the lw destination is rt.
  - RegDst is irrelevant to the hazard check, since loads always write rt.
- $zero destinations never stall.

Decomposition:
- Shared package mips_pkg holds:
  - ALUop encodings: ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_RTYPE = 2'b10.
  - Funct constants: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A.
  - REG_ZERO = 5'd0.
  - A bundled ID/EX control struct.
- One sub-module, load_use_detect: pure combinational comparator producing load_use_stall.
  - It is reused later by the forwarding unit's verification.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary id_* inputs -> all ex_* = 0, ex_valid = 0, bubble_cnt = 0, load_use_stall = 0.
- R-type pass-through: id_valid = 1, id_ALUop = 10, id_Func = 6'h22, id_rs_data = 5, id_rt_data = 3, id_rd = 9, id_RegWrite = 1 -> next edge ex_ALUop = 10, ex_Func = 6'h22, ex_rs_data = 5, ex_rd = 9, ex_valid = 1.
- Load-use: EX holds lw (ex_MemRead = 1, ex_rt = 8); ID presents add with rs = 8 ->
  - load_use_stall = 1 in the same cycle.
  - Next edge: ex_valid = 0, ex_RegWrite = 0, bubble_cnt = 1.
  - Following edge (stall clear): add loaded.
- Zero register: same as the load-use case but ex_rt = 0 and id_rs = 0 -> load_use_stall = 0, no bubble, bubble_cnt unchanged.
- Flush vs hold vs stall: flush = 1, hold = 1, and a load-use condition in the same cycle ->
  - load_use_stall = 0.
  - Next edge: bubble loaded, bubble_cnt unchanged.
  - With hold = 1 alone for 3 cycles: ex_* constant across all three.
- Saturation: preload bubble_cnt near max by forcing 65540 load-use cycles (or CW = 4 with 20 cycles) -> bubble_cnt stops at all-ones and does not wrap to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline encodings and the bundled ID/EX control word
package mips_pkg;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic [5:0] func;
    logic       reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch;
  } idex_ctrl_t;
  localparam idex_ctrl_t CTRL_BUBBLE = '{alu_op: ALUOP_ADD, default: '0};
endpackage

// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: ID-side inputs, EX-side registered outputs and pipeline control of the ID/EX register
interface id_ex_reg_if #(parameter int DW = 32, parameter int CW = 16);
  logic          id_valid, ex_valid;
  logic [1:0]    id_ALUop, ex_ALUop;
  logic [5:0]    id_Func, ex_Func;
  logic          id_RegDst, id_ALUSrc, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_Branch;
  logic          ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite, ex_Branch;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]    id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  logic          flush, hold, load_use_stall;
  logic [CW-1:0] bubble_cnt;
  modport master (
    output id_valid, id_ALUop, id_Func, id_RegDst, id_ALUSrc, id_MemRead, id_MemWrite, id_MemtoReg,
           id_RegWrite, id_Branch, id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, flush, hold,
    input  ex_valid, ex_ALUop, ex_Func, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg,
           ex_RegWrite, ex_Branch, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
           load_use_stall, bubble_cnt
  );
  modport slave (
    input  id_valid, id_ALUop, id_Func, id_RegDst, id_ALUSrc, id_MemRead, id_MemWrite, id_MemtoReg,
           id_RegWrite, id_Branch, id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, flush, hold,
    output ex_valid, ex_ALUop, ex_Func, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg,
           ex_RegWrite, ex_Branch, ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
           load_use_stall, bubble_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the rt destination of a load sitting in EX
module load_use_detect import mips_pkg::*; (
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       flush,
  output logic       stall
);
  assign stall = id_valid & ex_valid & ex_mem_read & (ex_rt != REG_ZERO) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use bubbling, branch flush, hold and a bubble counter
module id_ex_reg import mips_pkg::*; #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic        clk,
  input logic        reset,
  id_ex_reg_if.slave b
);
  idex_ctrl_t    id_c, ex_c;
  logic [DW-1:0] rs_data, rt_data, imm, pc4;
  logic [4:0]    rs, rt, rd;
  logic [CW-1:0] cnt;
  logic          stall, bubble;
  assign id_c = '{valid: b.id_valid, alu_op: b.id_ALUop, func: b.id_Func, reg_dst: b.id_RegDst,
                  alu_src: b.id_ALUSrc, mem_read: b.id_MemRead, mem_write: b.id_MemWrite,
                  mem_to_reg: b.id_MemtoReg, reg_write: b.id_RegWrite, branch: b.id_Branch};
  load_use_detect u_lud (
    .id_valid(b.id_valid), .id_rs(b.id_rs), .id_rt(b.id_rt),
    .ex_valid(ex_c.valid), .ex_mem_read(ex_c.mem_read), .ex_rt(rt),
    .flush(b.flush), .stall(stall)
  );
  // flush outranks hold so a taken branch still kills the instruction during a downstream stall
  assign bubble = reset | b.flush | (~b.hold & stall);
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_c    <= CTRL_BUBBLE;
      rs_data <= '0;
      rt_data <= '0;
      imm     <= '0;
      pc4     <= '0;
      rs      <= '0;
      rt      <= '0;
      rd      <= '0;
    end else if (!b.hold) begin
      ex_c    <= id_c;
      rs_data <= b.id_rs_data;
      rt_data <= b.id_rt_data;
      imm     <= b.id_imm;
      pc4     <= b.id_pc4;
      rs      <= b.id_rs;
      rt      <= b.id_rt;
      rd      <= b.id_rd;
    end
    if (reset) cnt <= '0;
    else if (!b.hold && stall && !(&cnt)) cnt <= cnt + 1'b1;
  end
  assign b.ex_valid       = ex_c.valid;
  assign b.ex_ALUop       = ex_c.alu_op;
  assign b.ex_Func        = ex_c.func;
  assign b.ex_RegDst      = ex_c.reg_dst;
  assign b.ex_ALUSrc      = ex_c.alu_src;
  assign b.ex_MemRead     = ex_c.mem_read;
  assign b.ex_MemWrite    = ex_c.mem_write;
  assign b.ex_MemtoReg    = ex_c.mem_to_reg;
  assign b.ex_RegWrite    = ex_c.reg_write;
  assign b.ex_Branch      = ex_c.branch;
  assign b.ex_rs_data     = rs_data;
  assign b.ex_rt_data     = rt_data;
  assign b.ex_imm         = imm;
  assign b.ex_pc4         = pc4;
  assign b.ex_rs          = rs;
  assign b.ex_rt          = rt;
  assign b.ex_rd          = rd;
  assign b.load_use_stall = stall;
  assign b.bubble_cnt     = cnt;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed bench with an instruction-level model of the ID/EX register
module tb_id_ex_reg;
  import mips_pkg::*;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = 2 ** CW - 1;
  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } ins_t;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  id_ex_reg_if #(.DW(DW), .CW(CW)) bif ();
  id_ex_reg #(.DW(DW), .CW(CW)) dut (.clk(clk), .reset(reset), .b(bif));
  int errors = 0;
  int checks = 0;
  ins_t ex_now, id_now, m_ex;
  int m_cnt = 0;
  assign ex_now = {bif.ex_valid, bif.ex_ALUop, bif.ex_Func, bif.ex_RegDst, bif.ex_ALUSrc, bif.ex_MemRead,
                   bif.ex_MemWrite, bif.ex_MemtoReg, bif.ex_RegWrite, bif.ex_Branch, bif.ex_rs_data,
                   bif.ex_rt_data, bif.ex_imm, bif.ex_pc4, bif.ex_rs, bif.ex_rt, bif.ex_rd};
  assign id_now = {bif.id_valid, bif.id_ALUop, bif.id_Func, bif.id_RegDst, bif.id_ALUSrc, bif.id_MemRead,
                   bif.id_MemWrite, bif.id_MemtoReg, bif.id_RegWrite, bif.id_Branch, bif.id_rs_data,
                   bif.id_rt_data, bif.id_imm, bif.id_pc4, bif.id_rs, bif.id_rt, bif.id_rd};
  function automatic logic hazard(ins_t e, ins_t i, logic fl);
    return i.valid && e.valid && e.memread && e.rt != 0 && (e.rt == i.rs || e.rt == i.rt) && !fl;
  endfunction
  // model: what instruction EX holds after each edge, and how many load-use bubbles so far
  always @(posedge clk) begin : model
    logic hz;
    hz = hazard(m_ex, id_now, bif.flush);
    if (reset) begin
      m_ex = '0;
      m_cnt = 0;
    end else if (bif.flush) m_ex = '0;
    else if (bif.hold) m_ex = m_ex;
    else if (hz) begin
      m_ex = '0;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else m_ex = id_now;
  end
  always @(negedge clk) begin
    checks++;
    if (ex_now !== m_ex) begin
      errors++;
      $display("FAIL ex_state actual=%h required=%h", ex_now, m_ex);
    end
    checks++;
    if (bif.load_use_stall !== hazard(m_ex, id_now, bif.flush)) begin
      errors++;
      $display("FAIL stall_model actual=%b required=%b", bif.load_use_stall, hazard(m_ex, id_now, bif.flush));
    end
    checks++;
    if (bif.bubble_cnt !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL cnt_model actual=%0d required=%0d", bif.bubble_cnt, m_cnt);
    end
  end
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic put(ins_t i);
    {bif.id_valid, bif.id_ALUop, bif.id_Func, bif.id_RegDst, bif.id_ALUSrc, bif.id_MemRead, bif.id_MemWrite,
     bif.id_MemtoReg, bif.id_RegWrite, bif.id_Branch, bif.id_rs_data, bif.id_rt_data, bif.id_imm, bif.id_pc4,
     bif.id_rs, bif.id_rt, bif.id_rd} = i;
  endtask
  function automatic ins_t rtype(logic [5:0] fn, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                 logic [31:0] a, logic [31:0] c);
    ins_t i = '0;
    i.valid = 1; i.aluop = ALUOP_RTYPE; i.func = fn; i.regdst = 1; i.regwrite = 1;
    i.rs_data = a; i.rt_data = c; i.pc4 = 32'h104; i.rs = s; i.rt = t; i.rd = d;
    return i;
  endfunction
  function automatic ins_t lw(logic [4:0] s, logic [4:0] t, logic [31:0] off);
    ins_t i = '0;
    i.valid = 1; i.aluop = ALUOP_ADD; i.alusrc = 1; i.memread = 1; i.memtoreg = 1; i.regwrite = 1;
    i.rs_data = 32'h40; i.imm = off; i.pc4 = 32'h100; i.rs = s; i.rt = t;
    return i;
  endfunction
  initial begin
    logic [191:0] rv;
    ins_t r;
    bif.flush = 0;
    bif.hold = 0;
    rv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = rv[$bits(ins_t)-1:0];
    put(r);
    cyc();
    cyc();
    chk("reset_ex_all", 64'(|ex_now), 0);
    chk("reset_valid", bif.ex_valid, 0);
    chk("reset_cnt", bif.bubble_cnt, 0);
    chk("reset_stall", bif.load_use_stall, 0);
    reset = 0;
    put(rtype(FN_SUB, 1, 2, 9, 5, 3));
    cyc();
    chk("rtype_aluop", bif.ex_ALUop, 2'b10);
    chk("rtype_func", bif.ex_Func, 6'h22);
    chk("rtype_rs_data", bif.ex_rs_data, 5);
    chk("rtype_rd", bif.ex_rd, 9);
    chk("rtype_valid", bif.ex_valid, 1);
    put(lw(3, 8, 4));
    cyc();
    chk("lw_memread", bif.ex_MemRead, 1);
    put(rtype(FN_ADD, 8, 4, 10, 11, 12));
    #2;
    chk("lu_stall_rs", bif.load_use_stall, 1);
    cyc();
    chk("lu_bubble_valid", bif.ex_valid, 0);
    chk("lu_bubble_regwrite", bif.ex_RegWrite, 0);
    chk("lu_cnt1", bif.bubble_cnt, 1);
    #2;
    chk("lu_stall_clear", bif.load_use_stall, 0);
    cyc();
    chk("lu_add_func", bif.ex_Func, FN_ADD);
    chk("lu_add_rd", bif.ex_rd, 10);
    put(lw(3, 7, 0));
    cyc();
    put(rtype(FN_OR, 5, 7, 11, 1, 2));
    #2;
    chk("lu_stall_rt", bif.load_use_stall, 1);
    cyc();
    chk("lu_cnt2", bif.bubble_cnt, 2);
    cyc();
    put(lw(3, 0, 8));
    cyc();
    put(rtype(FN_AND, 0, 0, 12, 1, 2));
    #2;
    chk("zero_stall", bif.load_use_stall, 0);
    cyc();
    chk("zero_loaded_rd", bif.ex_rd, 12);
    chk("zero_cnt", bif.bubble_cnt, 2);
    put(lw(3, 8, 0));
    cyc();
    put(rtype(FN_SLT, 8, 1, 13, 1, 2));
    bif.flush = 1;
    bif.hold = 1;
    #2;
    chk("flush_stall", bif.load_use_stall, 0);
    cyc();
    chk("flush_valid", bif.ex_valid, 0);
    chk("flush_memread", bif.ex_MemRead, 0);
    chk("flush_cnt", bif.bubble_cnt, 2);
    bif.flush = 0;
    bif.hold = 0;
    put(rtype(FN_SUB, 4, 5, 14, 7, 8));
    cyc();
    bif.hold = 1;
    for (int k = 0; k < 3; k++) begin
      put(rtype(FN_ADD, 1, 2, 5'(20 + k), 32'(k), 0));
      cyc();
      chk("hold_rd", bif.ex_rd, 14);
      chk("hold_func", bif.ex_Func, FN_SUB);
    end
    bif.hold = 0;
    put(lw(3, 9, 0));
    cyc();
    bif.hold = 1;
    put(rtype(FN_ADD, 9, 0, 15, 1, 2));
    #2;
    chk("hold_stall_out", bif.load_use_stall, 1);
    cyc();
    chk("hold_stall_keep", bif.ex_MemRead, 1);
    chk("hold_stall_cnt", bif.bubble_cnt, 2);
    bif.hold = 0;
    cyc();
    chk("unhold_cnt", bif.bubble_cnt, 3);
    r = rtype(FN_ADD, 1, 2, 3, 4, 5);
    r.aluop = 2'b11;
    put(r);
    cyc();
    chk("aluop11", bif.ex_ALUop, 2'b11);
    for (int k = 0; k < 20; k++) begin
      put(lw(3, 8, 0));
      cyc();
      put(rtype(FN_ADD, 8, 0, 1, 1, 1));
      cyc();
    end
    chk("sat_cnt", bif.bubble_cnt, CMAX);
    put(lw(3, 8, 0));
    cyc();
    put(rtype(FN_ADD, 8, 0, 1, 1, 1));
    cyc();
    chk("sat_no_wrap", bif.bubble_cnt, CMAX);
    put(lw(3, 8, 0));
    cyc();
    put(rtype(FN_ADD, 8, 0, 2, 1, 1));
    bif.flush = 1;
    bif.hold = 1;
    reset = 1;
    cyc();
    chk("midreset_all", 64'(|ex_now), 0);
    chk("midreset_cnt", bif.bubble_cnt, 0);
    reset = 0;
    bif.flush = 0;
    bif.hold = 0;
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
